// File: rtl/cello_sweep_pkg.sv
// Shared types and sizes for the 3-input truth-table sweeper.
package cello_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_t;

  localparam int unsigned NUM_COMBOS = 8;
  localparam int unsigned COMBO_W    = 3;
  localparam int unsigned TABLE_W    = 8;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Counts the cycles a combo has been held; expired flags the final settle cycle.
module settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input combos of a 3-input logic block, samples its output after
// a settle time and assembles the observed truth table (bit 7 = combo 000).
module truth_table_sweeper
  import cello_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 4,
  parameter logic [TABLE_W-1:0] EXPECTED      = 8'h1D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               in1,
  output logic               in2,
  output logic               in3,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] table_q,
  output logic               match
);

  localparam logic [COMBO_W-1:0] LAST_COMBO = COMBO_W'(NUM_COMBOS - 1);
  localparam logic [COMBO_W-1:0] TOP_BIT    = COMBO_W'(TABLE_W - 1);

  sweep_state_t       state_q, state_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [TABLE_W-1:0] table_d;
  logic               match_q, match_d;
  logic               cnt_clear, cnt_en, cnt_expired;
  logic [COMBO_W-1:0] bit_idx;

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .expired(cnt_expired)
  );

  assign bit_idx = TOP_BIT - combo_q;

  always_comb begin
    state_d   = state_q;
    combo_d   = combo_q;
    table_d   = table_q;
    match_d   = match_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETTLE;
          combo_d   = '0;
          table_d   = '0;
          match_d   = 1'b0;
          cnt_clear = 1'b1;
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[bit_idx] = dut_out;
        cnt_clear        = 1'b1;
        if (combo_q == LAST_COMBO) begin
          state_d = DONE;
          // Compare the table including this final sample so match is valid with done.
          match_d = (table_d == EXPECTED);
        end else begin
          combo_d = combo_q + COMBO_W'(1);
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      combo_q <= '0;
      table_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      combo_q <= combo_d;
      table_q <= table_d;
      match_q <= match_d;
    end
  end

  // Inputs are gated by state so they read 000 outside an active sweep.
  assign {in1, in2, in3} = ((state_q == SETTLE) || (state_q == SAMPLE)) ? combo_q : '0;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign match           = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with SETTLE_CYCLES=4, one with 1.
module tb_truth_table_sweeper;

  logic       clk;
  logic       reset;
  logic       start_s [2];
  logic       in1_s   [2];
  logic       in2_s   [2];
  logic       in3_s   [2];
  logic       dout_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [7:0] tbl_s   [2];
  logic       match_s [2];
  int         mode_s  [2];
  logic [7:0] rule_c;

  int checks = 0;
  int errors = 0;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'h1D)) u_a (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .in1(in1_s[0]), .in2(in2_s[0]), .in3(in3_s[0]), .dut_out(dout_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .table_q(tbl_s[0]), .match(match_s[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h1D)) u_b (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .in1(in1_s[1]), .in2(in2_s[1]), .in3(in3_s[1]), .dut_out(dout_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .table_q(tbl_s[1]), .match(match_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logic block under test: mode 0 = rule 0x1D, 1 = stuck-at-0, 2 = stuck-at-1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] c;
      c = {in1_s[i], in2_s[i], in3_s[i]};
      if (mode_s[i] == 0)      dout_s[i] = rule_c[3'd7 - c];
      else if (mode_s[i] == 1) dout_s[i] = 1'b0;
      else                     dout_s[i] = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep, comparing busy and the driven combo every cycle against a
  // formula, with optional extra start pulses during cycles xs1/xs2.
  task automatic run_sweep(input int inst, input int mode, input int settle,
                           input int xs1, input int xs2,
                           output int done_cyc, output int tbl, output int m,
                           output int trace_err, output int idle_err);
    int k;
    int exp_combo;
    done_cyc  = -1;
    tbl       = -1;
    m         = -1;
    trace_err = 0;
    idle_err  = 0;
    mode_s[inst]  = mode;
    start_s[inst] = 1'b1;
    tick();
    start_s[inst] = 1'b0;
    for (k = 1; k <= 200; k++) begin
      exp_combo = (k <= 8 * (settle + 1)) ? (k - 1) / (settle + 1) : 0;
      if ({in1_s[inst], in2_s[inst], in3_s[inst]} != 3'(exp_combo)) trace_err++;
      if (busy_s[inst] !== 1'b1) trace_err++;
      if (done_s[inst] === 1'b1) begin
        done_cyc = k;
        tbl      = int'(tbl_s[inst]);
        m        = int'(match_s[inst]);
        break;
      end
      start_s[inst] = (k == xs1 || k == xs2);
      tick();
      start_s[inst] = 1'b0;
    end
    start_s[inst] = (k == xs1 || k == xs2);
    tick();
    start_s[inst] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (busy_s[inst] !== 1'b0 || done_s[inst] !== 1'b0) idle_err++;
      if ({in1_s[inst], in2_s[inst], in3_s[inst]} != 3'b000) idle_err++;
      if (int'(tbl_s[inst]) != tbl || int'(match_s[inst]) != m) idle_err++;
      tick();
    end
  endtask

  typedef struct {
    string      name;
    int         inst;
    int         mode;
    int         settle;
    int         xs1;
    int         xs2;
    logic [7:0] exp_tbl;
    logic       exp_match;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dc, tb, mm, te, ie;
    int early_done;

    rule_c = 8'h1D;
    vecs[0] = '{"rule1d_s4",  0, 0, 4, 0,  0,  8'h1D, 1'b1, 41};
    vecs[1] = '{"stuck0_s4",  0, 1, 4, 0,  0,  8'h00, 1'b0, 41};
    vecs[2] = '{"stuck1_s4",  0, 2, 4, 0,  0,  8'hFF, 1'b0, 41};
    vecs[3] = '{"restart_s4", 0, 0, 4, 10, 41, 8'h1D, 1'b1, 41};
    vecs[4] = '{"rule1d_s1",  1, 0, 1, 0,  0,  8'h1D, 1'b1, 17};
    vecs[5] = '{"stuck1_s1",  1, 2, 1, 0,  0,  8'hFF, 1'b0, 17};

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 0;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 2; i++) begin
      check("reset_inputs", int'({in1_s[i], in2_s[i], in3_s[i]}), 0);
      check("reset_busy_done", int'({busy_s[i], done_s[i]}), 0);
      check("reset_table", int'(tbl_s[i]), 0);
      check("reset_match", int'(match_s[i]), 0);
    end

    foreach (vecs[v]) begin
      run_sweep(vecs[v].inst, vecs[v].mode, vecs[v].settle, vecs[v].xs1, vecs[v].xs2,
                dc, tb, mm, te, ie);
      check({vecs[v].name, "_done_cycle"}, dc, vecs[v].exp_done);
      check({vecs[v].name, "_table"}, tb, int'(vecs[v].exp_tbl));
      check({vecs[v].name, "_match"}, mm, int'(vecs[v].exp_match));
      check({vecs[v].name, "_trace"}, te, 0);
      check({vecs[v].name, "_post_done"}, ie, 0);
    end

    // Reset during combo 3 (cycle 17 of a SETTLE_CYCLES=4 sweep).
    mode_s[0]  = 0;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int k = 1; k < 17; k++) tick();
    check("pre_reset_combo3", int'({in1_s[0], in2_s[0], in3_s[0]}), 3);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_inputs", int'({in1_s[0], in2_s[0], in3_s[0]}), 0);
    check("midreset_busy_done", int'({busy_s[0], done_s[0]}), 0);
    check("midreset_table", int'(tbl_s[0]), 0);
    check("midreset_match", int'(match_s[0]), 0);
    tick();
    reset = 1'b0;
    early_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) early_done++;
      tick();
    end
    check("midreset_no_done", early_done, 0);

    run_sweep(0, 0, 4, 0, 0, dc, tb, mm, te, ie);
    check("after_reset_done_cycle", dc, 41);
    check("after_reset_table", tb, 8'h1D);
    check("after_reset_match", mm, 1);
    check("after_reset_trace", te, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
